// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM sequencing instructions over a shared req/ready memory port.
// Optional performance counters are enabled with `define CONTROL_PERF_CNT_EN.
module multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        instruction,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               Branch,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal,
  output logic               mem_fault
`ifdef CONTROL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    WB_MEM   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Last wait cycle index: a still-low mem_ready here trips the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_r, next_s;
  logic [7:0]  wait_cnt_r;
  logic        mem_fault_r;
  logic        wait_last_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        bit30_s;

  assign opcode_s    = instruction[6:0];
  assign funct3_s    = instruction[9:7];
  assign bit30_s     = instruction[10];
  assign wait_last_s = (wait_cnt_r == WAIT_LAST);
  assign mem_fault   = mem_fault_r;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30, input logic is_r);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= FETCH;
    else     state_r <= next_s;
  end

  // Memory wait counter and sticky timeout fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r  <= 8'd0;
      mem_fault_r <= 1'b0;
    end else if (mem_req && !mem_ready) begin
      if (wait_last_s) begin
        wait_cnt_r  <= 8'd0;
        mem_fault_r <= 1'b1;
      end else begin
        wait_cnt_r  <= wait_cnt_r + 8'd1;
        mem_fault_r <= mem_fault_r;
      end
    end else begin
      wait_cnt_r  <= 8'd0;
      mem_fault_r <= mem_fault_r;
    end
  end

  // Next-state and Moore output decode; outputs held idle while in reset
  always_comb begin
    next_s   = state_r;
    mem_req  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 1'b0;
    ALUOp    = ALUOP_W'(ALU_ADD);
    illegal  = 1'b0;
    if (rst) begin
      next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready)        next_s = DECODE;
          else if (wait_last_s) next_s = HALT;
          else                  next_s = FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b10;
          case (opcode_s)
            7'b0110011: next_s = EXEC_R;
            7'b0010011: next_s = EXEC_I;
            7'b0000011: next_s = MEM_ADDR;
            7'b0100011: next_s = MEM_ADDR;
            7'b1100011: next_s = BRANCH;
            default: begin
              illegal = 1'b1;
              next_s  = FETCH;
            end
          endcase
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_W'(alu_decode(funct3_s, bit30_s, 1'b1));
          next_s  = WB_ALU;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = ALUOP_W'(alu_decode(funct3_s, bit30_s, 1'b0));
          next_s  = WB_ALU;
        end
        WB_ALU: begin
          RegWrite = 1'b1;
          next_s   = FETCH;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          next_s  = (opcode_s == 7'b0100011) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          if (mem_ready)        next_s = WB_MEM;
          else if (wait_last_s) next_s = HALT;
          else                  next_s = MEM_RD;
        end
        WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          next_s   = FETCH;
        end
        MEM_WR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          if (mem_ready)        next_s = FETCH;
          else if (wait_last_s) next_s = HALT;
          else                  next_s = MEM_WR;
        end
        BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_W'(ALU_SUB);
          PCSource = 1'b1;
          case (funct3_s)
            3'b000:  Branch  = zero;
            3'b001:  Branch  = !zero;
            default: illegal = 1'b1;
          endcase
          next_s = FETCH;
        end
        HALT:    next_s = HALT;
        default: next_s = FETCH;
      endcase
    end
  end

`ifdef CONTROL_PERF_CNT_EN
  logic retire_s;

  // Retirement: completed instructions returning to FETCH; bad branches excluded
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      WB_ALU:  retire_s = 1'b1;
      WB_MEM:  retire_s = 1'b1;
      MEM_WR:  retire_s = mem_ready;
      BRANCH:  retire_s = (funct3_s == 3'b000) || (funct3_s == 3'b001);
      default: retire_s = 1'b0;
    endcase
  end

  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= {CNT_W{1'b0}};
      instret_cnt <= {CNT_W{1'b0}};
    end else begin
      cycle_cnt   <= (state_r != HALT) ? cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1} : cycle_cnt;
      instret_cnt <= retire_s ? instret_cnt + {{(CNT_W-1){1'b0}}, 1'b1} : instret_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction flow and checks
// the packed control vector against hand-derived per-state values.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [10:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, PCWrite, Branch, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite;
  logic        ALUSrcA, PCSource, illegal, mem_fault;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUOp;
`ifdef CONTROL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks;
  int failures;
  logic [17:0] obs;
  logic [17:0] exp_v;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .Branch(Branch), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .illegal(illegal), .mem_fault(mem_fault)
`ifdef CONTROL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Order: req pcw br irw mr mw m2r rw sa sb[1:0] pcs op[3:0] ill flt
  assign obs = {mem_req, PCWrite, Branch, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal, mem_fault};

  localparam logic [17:0] V_ZERO      = 18'd0;
  localparam logic [17:0] V_HALT      = 18'd1;
  localparam logic [17:0] V_FETCH_RDY = {4'b1101, 4'b0000, 1'b0, 2'b01, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_FETCH_WT  = {4'b1000, 4'b0000, 1'b0, 2'b01, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_DECODE    = {4'b0000, 4'b0000, 1'b0, 2'b10, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_DEC_ILL   = {4'b0000, 4'b0000, 1'b0, 2'b10, 1'b0, 4'd0, 2'b10};
  localparam logic [17:0] V_WB_ALU    = {4'b0000, 4'b0001, 1'b0, 2'b00, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_MEM_ADDR  = {4'b0000, 4'b0000, 1'b1, 2'b10, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_MEM_RD    = {4'b1000, 4'b1000, 1'b0, 2'b00, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_WB_MEM    = {4'b0000, 4'b0011, 1'b0, 2'b00, 1'b0, 4'd0, 2'b00};
  localparam logic [17:0] V_MEM_WR    = {4'b1000, 4'b0100, 1'b0, 2'b00, 1'b0, 4'd0, 2'b00};

  function automatic logic [17:0] mk_exec(input logic [3:0] op, input logic [1:0] sb);
    return {8'b0000_0000, 1'b1, sb, 1'b0, op, 2'b00};
  endfunction

  function automatic logic [17:0] mk_branch(input logic br, input logic ill);
    return {2'b00, br, 5'b00000, 1'b1, 2'b00, 1'b1, 4'd1, ill, 1'b0};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; instruction = 11'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_ZERO) begin failures++; $display("FAIL reset_outputs got=%h want=%h", obs, V_ZERO); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    instruction = {1'b0, 3'b000, 7'b0110011}; mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH_RDY) begin failures++; $display("FAIL add_fetch got=%h want=%h", obs, V_FETCH_RDY); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_DECODE) begin failures++; $display("FAIL add_decode got=%h want=%h", obs, V_DECODE); end
    @(negedge clk); #1;
    exp_v = mk_exec(4'd0, 2'b00);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL add_exec got=%h want=%h", obs, exp_v); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_WB_ALU) begin failures++; $display("FAIL add_wb got=%h want=%h", obs, V_WB_ALU); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_FETCH_RDY) begin failures++; $display("FAIL add_refetch got=%h want=%h", obs, V_FETCH_RDY); end
  endtask

  task automatic test_sub_srai();
    instruction = {1'b1, 3'b000, 7'b0110011}; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    exp_v = mk_exec(4'd1, 2'b00);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sub_exec got=%h want=%h", obs, exp_v); end
    repeat (2) @(negedge clk);
    instruction = {1'b1, 3'b101, 7'b0010011};
    repeat (2) @(negedge clk);
    #1;
    exp_v = mk_exec(4'd7, 2'b10);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL srai_exec got=%h want=%h", obs, exp_v); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_wait();
    instruction = {1'b0, 3'b010, 7'b0000011}; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_MEM_ADDR) begin failures++; $display("FAIL lw_addr got=%h want=%h", obs, V_MEM_ADDR); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== V_MEM_RD) begin failures++; $display("FAIL lw_wait%0d got=%h want=%h", i, obs, V_MEM_RD); end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_MEM_RD) begin failures++; $display("FAIL lw_done got=%h want=%h", obs, V_MEM_RD); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_WB_MEM) begin failures++; $display("FAIL lw_wb got=%h want=%h", obs, V_WB_MEM); end
    @(negedge clk);
  endtask

  task automatic test_store();
    instruction = {1'b0, 3'b010, 7'b0100011}; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_MEM_WR) begin failures++; $display("FAIL sw_write got=%h want=%h", obs, V_MEM_WR); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_FETCH_RDY) begin failures++; $display("FAIL sw_refetch got=%h want=%h", obs, V_FETCH_RDY); end
  endtask

  task automatic test_branch();
    zero = 1'b1; mem_ready = 1'b1;
    instruction = {1'b0, 3'b000, 7'b1100011};
    repeat (2) @(negedge clk);
    #1;
    exp_v = mk_branch(1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL beq_taken got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    instruction = {1'b0, 3'b001, 7'b1100011};
    repeat (2) @(negedge clk);
    #1;
    exp_v = mk_branch(1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL bne_not_taken got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    instruction = {1'b0, 3'b100, 7'b1100011};
    repeat (2) @(negedge clk);
    #1;
    exp_v = mk_branch(1'b0, 1'b1);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL branch_bad_f3 got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    instruction = {1'b0, 3'b000, 7'b1111111}; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs !== V_DEC_ILL) begin failures++; $display("FAIL illegal_decode got=%h want=%h", obs, V_DEC_ILL); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_FETCH_RDY) begin failures++; $display("FAIL illegal_next got=%h want=%h", obs, V_FETCH_RDY); end
  endtask

  task automatic test_timeout_boundary();
    instruction = {1'b0, 3'b000, 7'b1111111}; mem_ready = 1'b0;
    repeat (14) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH_RDY) begin failures++; $display("FAIL boundary_ready got=%h want=%h", obs, V_FETCH_RDY); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_DEC_ILL) begin failures++; $display("FAIL boundary_decode got=%h want=%h", obs, V_DEC_ILL); end
    @(negedge clk);
  endtask

  task automatic test_timeout_fault();
    mem_ready = 1'b0;
    repeat (13) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_FETCH_WT) begin failures++; $display("FAIL timeout_still_waiting got=%h want=%h", obs, V_FETCH_WT); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_HALT) begin failures++; $display("FAIL timeout_halt got=%h want=%h", obs, V_HALT); end
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_HALT) begin failures++; $display("FAIL halt_sticky got=%h want=%h", obs, V_HALT); end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== V_ZERO) begin failures++; $display("FAIL halt_reset got=%h want=%h", obs, V_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH_RDY) begin failures++; $display("FAIL post_reset_fetch got=%h want=%h", obs, V_FETCH_RDY); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub_srai();
    test_load_wait();
    test_store();
    test_branch();
    test_illegal();
    test_timeout_boundary();
    test_timeout_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. Same packed instruction-field input. Sequences each instruction through a Moore FSM over several cycles and handles wait states on a shared instruction/data memory via a req/ready handshake. Adds branch resolution, illegal-opcode detection and a memory-timeout fault. Sits between the datapath (IR, PC, ALU, register file) and the unified memory port.

Parameters:
ALUOP_W, 4, width of ALUOp; must be >= 4.
MEM_TIMEOUT, 15, max wait cycles on mem_ready before fault; legal range 1..255.
CNT_W, 32, width of performance counters (optional feature only).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instruction  in  11  {Instruction[30], Instruction[14:12], Instruction[6:0]}; sampled from IR, valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
PCWrite  out  1  unconditional PC load
Branch  out  1  conditional PC load; high only when branch is taken
IRWrite  out  1  load IR from memory read data
MemRead  out  1  data read (loads)
MemWrite  out  1  data write (stores)
MemtoReg  out  1  register write-back source: 1 = memory data, 0 = ALUOut
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = rs1
ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate
PCSource  out  1  0 = ALU result, 1 = ALUOut register
ALUOp  out  ALUOP_W  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
illegal  out  1  one-cycle pulse on unsupported opcode or funct3
mem_fault  out  1  sticky; set on memory timeout

Behaviour:
- Reset (async): state = FETCH, wait counter = 0, mem_fault = 0, all outputs 0 except ALUOp = ADD. First fetch starts on the first clock after rst deasserts.
- Outputs are decoded from state and instruction only (Moore). No output depends on mem_ready, except that write-enables qualify on mem_ready as stated per state.
- FETCH: mem_req = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = ADD, PCSource = 0. IRWrite and PCWrite = mem_ready. On mem_ready -> DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 10, ALUOp = ADD, which precomputes the branch target into ALUOut. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - anything else: illegal = 1, -> FETCH
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00. ALUOp from funct3: 000 gives SUB if bit30 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 gives SRA if bit30 else SRL; 110 OR; 111 AND. -> WB_ALU.
- EXEC_I: as EXEC_R but ALUSrcB = 10, and funct3 000 is always ADD (bit30 ignored). -> WB_ALU.
- WB_ALU: RegWrite = 1, MemtoReg = 0. -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = ADD. -> MEM_RD if load, MEM_WR if store.
- MEM_RD: mem_req = MemRead = 1. On mem_ready -> WB_MEM.
- WB_MEM: RegWrite = 1, MemtoReg = 1. -> FETCH.
- MEM_WR: mem_req = MemWrite = 1. On mem_ready -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = SUB, PCSource = 1.
  - funct3 000 (BEQ): Branch = zero.
  - funct3 001 (BNE): Branch = !zero.
  - Other funct3: Branch = 0, illegal = 1.
  - -> FETCH in all cases.
- Wait counter:
  - Increments each cycle mem_req = 1 and mem_ready = 0; clears on mem_ready or on leaving a memory state.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: set mem_fault, -> HALT.
  - mem_ready on exactly the MEM_TIMEOUT-th wait cycle completes normally.
- HALT: all outputs 0; remains until rst.
- Reset mid-access: returns to FETCH immediately; any pending req is dropped without completing.

Optional Feature:
CONTROL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt [CNT_W] and instret_cnt [CNT_W], both reset to 0.
  - cycle_cnt increments every cycle outside HALT.
  - instret_cnt increments on entry to FETCH from WB_ALU, WB_MEM, MEM_WR or BRANCH.
  - Illegal instructions are not counted as retired.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: ports and logic absent.

Test Plan:
- ADD x3, x1, x2 with instruction = {0,000,0110011}, mem_ready = 1 in FETCH -> FETCH, DECODE, EXEC_R (ALUOp = 0), WB_ALU (RegWrite = 1); back in FETCH on cycle 5.
- SUB then SRAI (bit30 = 1, funct3 = 101, opcode 0010011) -> ALUOp = 1 in EXEC_R; ALUOp = 7 with ALUSrcB = 10 in EXEC_I.
- LW with mem_ready held low 3 cycles in MEM_RD -> MemRead stays high 4 cycles; then WB_MEM with MemtoReg = 1, RegWrite = 1.
- BEQ with zero = 1, then BNE with zero = 1 -> Branch = 1 with PCSource = 1 on the first; Branch = 0 on the second.
- Opcode 1111111 -> illegal pulses exactly 1 cycle in DECODE; next state FETCH; no RegWrite, MemWrite or Branch asserted.
- mem_ready held low 15 cycles in FETCH (MEM_TIMEOUT = 15) -> mem_fault = 1, all outputs 0 thereafter; rst pulse mid-HALT -> FETCH, mem_fault = 0.
